countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter and load-value width in bits.
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  count qualifier; one decrement per clock with enable=1 in RUN.
REQ-005 The block SHALL have port load  input  1  synchronous load of cnt_in into cnt and into the reload register.
REQ-006 The block SHALL have port cnt_in  input  WIDTH  load value.
REQ-007 The block SHALL have port auto_reload  input  1  at terminal count: 1 = reload and keep running, 0 = stop in EXPIRED.
REQ-008 The block SHALL have port cnt  output  WIDTH  current count, registered.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse, registered, marking each terminal count.
REQ-010 The block SHALL have port busy  output  1  high while the FSM is in RUN.
REQ-011 The block SHALL have port expired  output  1  high while the FSM is in EXPIRED.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and EXPIRED.
REQ-013 load SHALL take priority over enable and over the terminal-count action in every state.
REQ-014 load with cnt_in != 0 SHALL set cnt=cnt_in and reload=cnt_in, and SHALL move the FSM to RUN on the next edge.
REQ-015 load with cnt_in == 0 SHALL set cnt=0 and reload=0, SHALL move the FSM to IDLE, and SHALL NOT assert done.
REQ-016 In RUN with enable=1, load=0 and cnt > 1, cnt SHALL decrement by 1 per clock.
REQ-017 In RUN with enable=0 and load=0, cnt and the FSM state SHALL hold.
REQ-018 Terminal count is RUN with enable=1, load=0 and cnt == 1; at that edge done SHALL be 1 for exactly the following cycle.
REQ-019 At terminal count with auto_reload=1, cnt SHALL become reload and the FSM SHALL stay in RUN; the period is therefore reload enabled cycles.
REQ-020 At terminal count with auto_reload=0, cnt SHALL become 0 and the FSM SHALL go to EXPIRED.
REQ-021 auto_reload SHALL be sampled only at the terminal-count edge.
REQ-022 In IDLE and EXPIRED, enable SHALL be ignored and cnt SHALL hold.
REQ-023 EXPIRED SHALL be left only by load or reset.
REQ-024 load in the terminal-count cycle SHALL suppress done and apply REQ-014/015.
REQ-025 cnt SHALL never wrap below 0.
REQ-026 busy and expired SHALL be decoded from the state register, with no combinational path from inputs.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force state=IDLE, cnt=0, reload=0, done=0, busy=0 and expired=0.
REQ-028 Assertion of reset mid-RUN SHALL discard any pending terminal count, and no done SHALL follow deassertion.
REQ-029 After deassertion of reset, the block SHALL remain in IDLE until load.

Structure
REQ-030 A shared package countdown_pkg SHALL hold the state enumeration (IDLE, RUN, EXPIRED) and the default WIDTH constant.
REQ-031 The loadable down-counter datapath SHALL be a sub-module named down_counter, with ports clock, reset, load, dec, d, q and is_one.
REQ-032 The FSM, reload register and done register SHALL reside in countdown_timer.

Verification
REQ-033 Scenario: reset, then load cnt_in=3 with enable=1 held and auto_reload=0 -> cnt 3,2,1,0; done is high one cycle as cnt reaches 0; expired=1 and busy=0 thereafter.
REQ-034 Scenario: load 2 with auto_reload=1 and enable=1 held for 8 cycles -> cnt 2,1,2,1,...; done pulses every 2nd cycle; busy stays 1.
REQ-035 Scenario: load 5, enable toggling 1,0,1,0 -> cnt decrements only on enabled cycles (5,4,4,3,3); done=0.
REQ-036 Scenario: load 0 -> state IDLE, cnt=0, done never asserts, and enable has no effect.
REQ-037 Scenario: at cnt=1 with enable=1, apply load with cnt_in=4 -> cnt=4, no done pulse, and the FSM stays in RUN.
REQ-038 Scenario: assert reset asynchronously mid-cycle at cnt=2 in RUN -> outputs clear immediately, with no done after release.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default width for the countdown timer
package countdown_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down-counter that saturates at zero
module down_counter
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = load ? d : (dec && q_q != '0) ? q_q - WIDTH'(1) : q_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
  assign is_one = q_q == WIDTH'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable countdown with done pulse, optional auto-reload and an IDLE/RUN/EXPIRED FSM
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             done,
  output logic             busy,
  output logic             expired
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d, ctr_d;
  logic done_q, done_d, tc, is_one, ctr_load;
  always_comb begin
    tc = state_q == RUN && enable && !load && is_one;
    state_d = load ? (cnt_in != '0 ? RUN : IDLE) : tc ? (auto_reload ? RUN : EXPIRED) : state_q;
    reload_d = load ? cnt_in : reload_q;
    done_d = tc;
    ctr_load = load || (tc && auto_reload);
    ctr_d = load ? cnt_in : reload_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      reload_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reload_q <= reload_d;
      done_q <= done_d;
    end
  down_counter #(.WIDTH(WIDTH)) u_ctr (
    .clock(clock),
    .reset(reset),
    .load(ctr_load),
    .dec(enable && state_q == RUN),
    .d(ctr_d),
    .q(cnt),
    .is_one(is_one)
  );
  assign done = done_q;
  assign busy = state_q == RUN;
  assign expired = state_q == EXPIRED;
endmodule
